// File: rtl/ahb_gpio_timer.sv
// AHB-Lite slave: LED output register, synchronised switch input,
// and a free-running 32-bit timer with compare-match interrupt.
`timescale 1ns/1ps
module ahb_gpio_timer #(
  parameter int          LED_WIDTH = 16,
  parameter int          SW_WIDTH  = 16,
  parameter logic [31:0] LED_RESET = 32'h0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 hsel,
  input  logic [31:0]          haddr,
  input  logic [1:0]           htrans,
  input  logic                 hwrite,
  input  logic [2:0]           hsize,
  input  logic [2:0]           hburst,
  input  logic [3:0]           hprot,
  input  logic                 hmastlock,
  input  logic [31:0]          hwdata,
  output logic [31:0]          hrdata,
  output logic                 hready,
  output logic                 hresp,
  input  logic [SW_WIDTH-1:0]  sw,
  output logic [LED_WIDTH-1:0] led,
  output logic                 irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t              state;
  logic [2:0]          d_reg;
  logic [1:0]          d_lo;
  logic [1:0]          d_size;
  logic                d_write;
  logic [SW_WIDTH-1:0] sw_s1;
  logic [SW_WIDTH-1:0] sw_s2;
  logic [31:0]         tcnt;
  logic [31:0]         tcmp;
  logic [1:0]          ctrl;
  logic                match;

  logic        accept;
  logic        misalign;
  logic        bad;
  logic        wr;
  logic        w1c;
  logic [3:0]  be;
  logic [31:0] mask;
  logic [31:0] wm;
  logic [31:0] keep;
  logic        unused_sink;

  assign unused_sink = ^{hburst, hprot, hmastlock, haddr[31:12]};

  assign accept   = hsel & htrans[1] & hready;
  assign misalign = (hsize == 3'd1 & haddr[0])
                  | (hsize == 3'd2 & |haddr[1:0]);
  assign bad      = (hsize > 3'd2) | misalign
                  | (haddr[11:0] >= 12'h020);

  assign wr  = (state == S_DATA) & d_write;
  assign wm  = hwdata & mask;
  assign keep = ~mask;
  assign w1c = wr & (d_reg == 3'd7) & wm[0];

  // little-endian byte lanes of the pending data phase
  always_comb begin
    be = 4'b0000;
    unique case (d_size)
      2'd0:    be = 4'b0001 << d_lo;
      2'd1:    be = d_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  end

  always_comb begin
    hrdata = '0;
    if (state == S_DATA && !d_write) begin
      unique case (d_reg)
        3'd0:    hrdata = 32'(led);
        3'd3:    hrdata = 32'(sw_s2);
        3'd4:    hrdata = tcnt;
        3'd5:    hrdata = {30'd0, ctrl};
        3'd6:    hrdata = tcmp;
        3'd7:    hrdata = {31'd0, match};
        default: hrdata = '0;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      hready  <= 1'b1;
      hresp   <= 1'b0;
      d_reg   <= '0;
      d_lo    <= '0;
      d_size  <= '0;
      d_write <= 1'b0;
      sw_s1   <= '0;
      sw_s2   <= '0;
      led     <= LED_RESET[LED_WIDTH-1:0];
      tcnt    <= '0;
      tcmp    <= '1;
      ctrl    <= '0;
      match   <= 1'b0;
      irq     <= 1'b0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;

      unique case (state)
        S_ERR1: begin
          state  <= S_ERR2;
          hready <= 1'b1;
          hresp  <= 1'b1;
        end
        default: begin
          state  <= S_IDLE;
          hready <= 1'b1;
          hresp  <= 1'b0;
          if (accept && bad) begin
            state  <= S_ERR1;
            hready <= 1'b0;
            hresp  <= 1'b1;
          end else if (accept) begin
            state   <= S_DATA;
            d_reg   <= haddr[4:2];
            d_lo    <= haddr[1:0];
            d_size  <= hsize[1:0];
            d_write <= hwrite;
          end
        end
      endcase

      if (ctrl[0])
        tcnt <= tcnt + 32'd1;

      // a bus write to TCNT overrides the increment above
      if (wr) begin
        unique case (d_reg)
          3'd0: led <= (led & keep[LED_WIDTH-1:0])
                     | wm[LED_WIDTH-1:0];
          3'd1: led <= led | wm[LED_WIDTH-1:0];
          3'd2: led <= led & ~wm[LED_WIDTH-1:0];
          3'd4: tcnt <= (tcnt & keep) | wm;
          3'd5: ctrl <= (ctrl & keep[1:0]) | wm[1:0];
          3'd6: tcmp <= (tcmp & keep) | wm;
          default: ;
        endcase
      end

      match <= (ctrl[0] && tcnt == tcmp) | (match & ~w1c);
      irq   <= match & ctrl[1];
    end
  end

endmodule

// File: tb/tb_ahb_gpio_timer.sv
// Bench for ahb_gpio_timer: directed table, corner sequences,
// and random traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_ahb_gpio_timer;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic [15:0] sw;
  logic [15:0] led;
  logic        irq;

  always #5 HCLK = ~HCLK;

  ahb_gpio_timer dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .hmastlock(hmastlock),
    .hwdata(hwdata), .hrdata(hrdata),
    .hready(hready), .hresp(hresp),
    .sw(sw), .led(led), .irq(irq)
  );

  int n_err = 0;
  int n_chk = 0;

  logic [31:0] s_hrdata;
  logic        s_hready;
  logic        s_hresp;
  logic [15:0] s_led;
  logic        s_irq;

  // reference model state
  logic [15:0] m_led;
  logic [31:0] m_tcnt;
  logic [31:0] m_tcmp;
  logic        m_en;
  logic        m_ie;
  logic        m_match;
  logic        m_irq;
  logic [15:0] m_s1;
  logic [15:0] m_s2;
  int          m_err_left;
  logic        p_valid;
  logic        p_write;
  logic [11:0] p_off;
  logic [2:0]  p_size;

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] d;
    logic [15:0] led_e;
    bit          err_e;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit is_bad(logic [31:0] a,
                                logic [2:0] sz);
    return (sz > 3'd2) || (sz == 3'd1 && a[0])
        || (sz == 3'd2 && a[1:0] != 2'b00)
        || (a[11:0] >= 12'h020);
  endfunction

  function automatic logic [31:0] m_read(logic [11:0] off);
    case (int'(off) / 4)
      0:       return {16'h0, m_led};
      3:       return {16'h0, m_s2};
      4:       return m_tcnt;
      5:       return {30'h0, m_ie, m_en};
      6:       return m_tcmp;
      7:       return {31'h0, m_match};
      default: return 32'h0;
    endcase
  endfunction

  // advance the model by one clock using the inputs now on the bus
  task automatic model_step();
    logic [15:0] n_led;
    logic [31:0] n_tw;
    logic [31:0] n_tcmp;
    logic [31:0] tmp;
    logic [7:0]  by;
    logic        n_en;
    logic        n_ie;
    bit          tw;
    bit          clr;
    int          lo;
    int          nb;
    if (!HRESETn) begin
      m_led = 16'h0; m_tcnt = 32'h0; m_tcmp = 32'hFFFFFFFF;
      m_en = 0; m_ie = 0; m_match = 0; m_irq = 0;
      m_s1 = 16'h0; m_s2 = 16'h0;
      m_err_left = 0; p_valid = 0; p_write = 0;
      p_off = 12'h0; p_size = 3'd0;
      return;
    end
    n_led = m_led; n_tw = m_tcnt; n_tcmp = m_tcmp;
    n_en = m_en; n_ie = m_ie; tw = 0; clr = 0;
    if (p_valid && p_write) begin
      lo = int'(p_off[1:0]);
      nb = 1 << p_size;
      for (int b = 0; b < 4; b++) begin
        if (b >= lo && b < lo + nb) begin
          by = hwdata[8*b +: 8];
          tmp = {24'h0, by} << (8 * b);
          case (int'(p_off) / 4)
            0: begin
              tmp = {16'h0, n_led};
              tmp[8*b +: 8] = by;
              n_led = tmp[15:0];
            end
            1: n_led = n_led | tmp[15:0];
            2: n_led = n_led & ~tmp[15:0];
            4: begin tw = 1; n_tw[8*b +: 8] = by; end
            5: if (b == 0) begin n_en = by[0]; n_ie = by[1]; end
            6: n_tcmp[8*b +: 8] = by;
            7: if (b == 0 && by[0]) clr = 1;
            default: ;
          endcase
        end
      end
    end
    m_irq = m_match && m_ie;
    m_match = (m_en && m_tcnt == m_tcmp) || (m_match && !clr);
    m_tcnt = tw ? n_tw : (m_en ? m_tcnt + 32'd1 : m_tcnt);
    m_led = n_led; m_tcmp = n_tcmp; m_en = n_en; m_ie = n_ie;
    m_s2 = m_s1; m_s1 = sw;
    if (m_err_left == 2) begin
      m_err_left = 1; p_valid = 0;
    end else if (hsel && htrans[1]) begin
      if (is_bad(haddr, hsize)) begin
        m_err_left = 2; p_valid = 0;
      end else begin
        m_err_left = 0; p_valid = 1; p_write = hwrite;
        p_off = haddr[11:0]; p_size = hsize;
      end
    end else begin
      m_err_left = 0; p_valid = 0;
    end
  endtask

  task automatic cyc();
    logic [31:0] exp_rd;
    @(negedge HCLK);
    s_hrdata = hrdata; s_hready = hready; s_hresp = hresp;
    s_led = led; s_irq = irq;
    exp_rd = (p_valid && !p_write) ? m_read(p_off) : 32'h0;
    chk("m_hready", s_hready, (m_err_left == 2) ? 0 : 1);
    chk("m_hresp", s_hresp, (m_err_left > 0) ? 1 : 0);
    chk("m_hrdata", s_hrdata, exp_rd);
    chk("m_led", s_led, m_led);
    chk("m_irq", s_irq, m_irq);
    @(posedge HCLK);
    model_step();
    #1;
  endtask

  task automatic ap(bit w, logic [31:0] a, logic [2:0] sz);
    hsel = 1; htrans = 2'b10; hwrite = w; haddr = a; hsize = sz;
  endtask

  task automatic ap_idle();
    hsel = 0; htrans = 2'b00; hwrite = 0;
    haddr = 32'h0; hsize = 3'd0;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d,
                    logic [2:0] sz);
    ap(1, a, sz); cyc();
    ap_idle(); hwdata = d; cyc();
  endtask

  task automatic rd(logic [31:0] a);
    ap(0, a, 3'd2); cyc();
    ap_idle(); cyc();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, 32'h000, 3'd2, 32'h000000F0, 16'h00F0, 0};
    tbl[1]  = '{1, 32'h004, 3'd0, 32'h0000000F, 16'h00FF, 0};
    tbl[2]  = '{1, 32'h008, 3'd1, 32'h000000F0, 16'h000F, 0};
    tbl[3]  = '{0, 32'h020, 3'd2, 32'h00000000, 16'h000F, 1};
    tbl[4]  = '{1, 32'h003, 3'd1, 32'hFFFFFFFF, 16'h000F, 1};
    tbl[5]  = '{1, 32'h000, 3'd3, 32'hFFFFFFFF, 16'h000F, 1};
    tbl[6]  = '{1, 32'h001, 3'd0, 32'h0000AB00, 16'hAB0F, 0};
    tbl[7]  = '{1, 32'h002, 3'd1, 32'h12340000, 16'hAB0F, 0};
    tbl[8]  = '{1, 32'h00C, 3'd2, 32'hFFFFFFFF, 16'hAB0F, 0};
    tbl[9]  = '{1, 32'h005, 3'd0, 32'h00004000, 16'hEB0F, 0};
    tbl[10] = '{1, 32'h1000, 3'd2, 32'h00000001, 16'h0001, 0};
    tbl[11] = '{0, 32'h01C, 3'd2, 32'h00000000, 16'h0001, 0};
    tbl[12] = '{1, 32'h022, 3'd1, 32'hFFFF0000, 16'h0001, 1};
    tbl[13] = '{1, 32'h008, 3'd0, 32'h00000001, 16'h0000, 0};

    HRESETn = 0; ap_idle(); hwdata = 0; sw = 16'h0;
    hburst = 0; hprot = 0; hmastlock = 0;
    @(posedge HCLK); model_step(); #1;
    cyc();
    chk("rst_hready", s_hready, 1);
    chk("rst_hresp", s_hresp, 0);
    chk("rst_hrdata", s_hrdata, 32'h0);
    chk("rst_led", s_led, 16'h0);
    chk("rst_irq", s_irq, 0);
    HRESETn = 1;

    // back-to-back write then read of LED_OUT
    ap(1, 32'h0, 3'd2); cyc();
    hwdata = 32'h0000A5A5; ap(0, 32'h0, 3'd2); cyc();
    chk("b2b_wr_rdy", s_hready, 1);
    chk("b2b_wr_resp", s_hresp, 0);
    ap_idle(); cyc();
    chk("b2b_rd_data", s_hrdata, 32'h0000A5A5);
    chk("b2b_led", s_led, 16'hA5A5);
    chk("b2b_rd_rdy", s_hready, 1);
    chk("b2b_rd_resp", s_hresp, 0);

    for (int i = 0; i < 14; i++) begin
      ap(tbl[i].w, tbl[i].a, tbl[i].sz); cyc();
      ap_idle(); hwdata = tbl[i].d; cyc();
      chk($sformatf("v%0d_rdy1", i), s_hready,
          tbl[i].err_e ? 0 : 1);
      chk($sformatf("v%0d_resp1", i), s_hresp,
          tbl[i].err_e ? 1 : 0);
      if (tbl[i].err_e) begin
        cyc();
        chk($sformatf("v%0d_rdy2", i), s_hready, 1);
        chk($sformatf("v%0d_resp2", i), s_hresp, 1);
      end
      cyc();
      chk($sformatf("v%0d_led", i), s_led, tbl[i].led_e);
    end

    // a NONSEQ offered while hready is low must be dropped
    wr(32'h0, 32'h00000123, 3'd2);
    ap(1, 32'h003, 3'd1); cyc();
    ap(1, 32'h000, 3'd2); hwdata = 32'h5555; cyc();
    chk("e1_rdy", s_hready, 0);
    chk("e1_resp", s_hresp, 1);
    ap_idle(); hwdata = 32'hFFFF; cyc();
    chk("e2_rdy", s_hready, 1);
    chk("e2_resp", s_hresp, 1);
    cyc(); cyc();
    chk("e1_ignored_led", s_led, 16'h0123);

    // compare match and interrupt timing
    wr(32'h18, 32'd5, 3'd2);
    wr(32'h10, 32'd0, 3'd2);
    wr(32'h14, 32'd3, 3'd2);
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk($sformatf("irq_c%0d", k), s_irq, (k >= 7) ? 1 : 0);
    end
    wr(32'h1C, 32'd1, 3'd2);
    rd(32'h1C);
    chk("w1c_clears", s_hrdata, 32'd0);
    ap(1, 32'h10, 3'd2); cyc();
    hwdata = 32'd5; ap(1, 32'h1C, 3'd2); cyc();
    hwdata = 32'd1; ap(0, 32'h1C, 3'd2); cyc();
    ap_idle(); cyc();
    chk("w1c_vs_set", s_hrdata, 32'd1);

    // wrap and write-over-increment
    ap(1, 32'h10, 3'd2); cyc();
    hwdata = 32'hFFFFFFFE; ap(0, 32'h10, 3'd2); cyc();
    ap(0, 32'h10, 3'd2); cyc();
    chk("wrap_fe", s_hrdata, 32'hFFFFFFFE);
    ap(0, 32'h10, 3'd2); cyc();
    chk("wrap_ff", s_hrdata, 32'hFFFFFFFF);
    ap_idle(); cyc();
    chk("wrap_0", s_hrdata, 32'h0);
    ap(1, 32'h10, 3'd2); cyc();
    hwdata = 32'h100; ap(0, 32'h10, 3'd2); cyc();
    ap_idle(); cyc();
    chk("tcnt_wr_wins", s_hrdata, 32'h100);

    // reset during ERR1
    wr(32'h0, 32'h1234, 3'd2);
    ap(0, 32'h20, 3'd2); cyc();
    ap_idle(); HRESETn = 0; cyc();
    chk("r1_in_err1", s_hready, 0);
    HRESETn = 1; cyc();
    chk("r1_hready", s_hready, 1);
    chk("r1_hresp", s_hresp, 0);
    chk("r1_hrdata", s_hrdata, 32'h0);
    chk("r1_led", s_led, 16'h0);
    chk("r1_irq", s_irq, 0);
    rd(32'h10); chk("r1_tcnt", s_hrdata, 32'h0);
    rd(32'h18); chk("r1_tcmp", s_hrdata, 32'hFFFFFFFF);
    rd(32'h14); chk("r1_ctrl", s_hrdata, 32'h0);

    // reset while counting with irq asserted
    wr(32'h18, 32'd2, 3'd2);
    wr(32'h14, 32'd3, 3'd2);
    repeat (6) cyc();
    chk("r2_irq_pre", s_irq, 1);
    HRESETn = 0; cyc();
    HRESETn = 1; cyc();
    chk("r2_irq", s_irq, 0);
    chk("r2_led", s_led, 16'h0);
    rd(32'h10); chk("r2_tcnt", s_hrdata, 32'h0);
    rd(32'h1C); chk("r2_status", s_hrdata, 32'h0);

    // synchroniser latency
    sw = 16'hBEEF; cyc(); sw = 16'h0;
    ap(0, 32'h0C, 3'd2); cyc();
    ap_idle(); cyc();
    chk("sw_sync", s_hrdata, 32'h0000BEEF);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      HRESETn = ($urandom_range(0, 60) != 0);
      hsel = ($urandom_range(0, 3) != 0);
      htrans = 2'($urandom);
      hwrite = 1'($urandom);
      hsize = ($urandom_range(0, 7) == 0)
            ? 3'($urandom_range(3, 7))
            : 3'($urandom_range(0, 2));
      haddr = ($urandom & 32'hFFFFF000)
            | 32'($urandom_range(0, 12'h023));
      hwdata = $urandom;
      hburst = 3'($urandom);
      hprot = 4'($urandom);
      hmastlock = 1'($urandom);
      sw = 16'($urandom);
      cyc();
    end

    HRESETn = 1; ap_idle();
    repeat (4) cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
